// File: rtl/cpu_pkg.sv
// Shared encodings for the simple RISC controller, decoder and datapath.
package cpu_pkg;

    localparam int unsigned OPC_W  = 3;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned NSEL_W = 3;
    localparam int unsigned VSEL_W = 2;

    // Controller states
    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_GET_A     = 3'd2,
        S_GET_B     = 3'd3,
        S_EXEC      = 3'd4,
        S_WRITE_REG = 3'd5,
        S_WRITE_IMM = 3'd6
    } state_t;

    // Opcode field (instruction[15:13])
    localparam logic [OPC_W-1:0] OPC_MOV = 3'b110;
    localparam logic [OPC_W-1:0] OPC_ALU = 3'b101;

    // Op field (instruction[12:11]) for OPC_ALU
    localparam logic [OP_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] OP_CMP = 2'b01;
    localparam logic [OP_W-1:0] OP_AND = 2'b10;
    localparam logic [OP_W-1:0] OP_MVN = 2'b11;

    // Op field for OPC_MOV
    localparam logic [OP_W-1:0] OP_MOVIMM = 2'b10;
    localparam logic [OP_W-1:0] OP_MOVREG = 2'b00;

    // One-hot register-field select
    localparam logic [NSEL_W-1:0] NSEL_NONE = 3'b000;
    localparam logic [NSEL_W-1:0] NSEL_RN   = 3'b001;
    localparam logic [NSEL_W-1:0] NSEL_RD   = 3'b010;
    localparam logic [NSEL_W-1:0] NSEL_RM   = 3'b100;

    // Writeback source select
    localparam logic [VSEL_W-1:0] VSEL_C     = 2'b00;
    localparam logic [VSEL_W-1:0] VSEL_PC    = 2'b01;
    localparam logic [VSEL_W-1:0] VSEL_IMM   = 2'b10;
    localparam logic [VSEL_W-1:0] VSEL_MDATA = 2'b11;

    // True for instructions that pass through the ALU and update status
    function automatic logic is_alu_instr(input logic [OPC_W-1:0] opcode,
                                          input logic [OP_W-1:0]  op);
        return (opcode == OPC_ALU) ||
               ((opcode == OPC_MOV) && (op == OP_MOVREG));
    endfunction

    // True for instructions whose ALU result bypasses A (operand A forced to zero)
    function automatic logic is_single_operand(input logic [OPC_W-1:0] opcode,
                                               input logic [OP_W-1:0]  op);
        return ((opcode == OPC_MOV) && (op == OP_MOVREG)) ||
               ((opcode == OPC_ALU) && (op == OP_MVN));
    endfunction

    // True for compare, which updates status but writes no register
    function automatic logic is_compare(input logic [OPC_W-1:0] opcode,
                                        input logic [OP_W-1:0]  op);
        return (opcode == OPC_ALU) && (op == OP_CMP);
    endfunction

endpackage

// File: rtl/cpu_controller.sv
// Instruction sequencing FSM for the 16-bit simple RISC datapath.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              s,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [OP_W-1:0]   op,
    output logic              w,
    output logic [NSEL_W-1:0] nsel,
    output logic [VSEL_W-1:0] vsel,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic              illegal
);

    state_t state_q;
    state_t state_d;

    // State register with synchronous reset back to WAIT
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d = state_q;
        w       = 1'b0;
        nsel    = NSEL_NONE;
        vsel    = VSEL_C;
        write   = 1'b0;
        loada   = 1'b0;
        loadb   = 1'b0;
        loadc   = 1'b0;
        loads   = 1'b0;
        asel    = 1'b0;
        bsel    = 1'b0;
        illegal = 1'b0;

        unique case (state_q)
            S_WAIT: begin
                w = 1'b1;
                if (s) begin
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                case ({opcode, op})
                    {OPC_MOV, OP_MOVIMM}: state_d = S_WRITE_IMM;
                    {OPC_MOV, OP_MOVREG}: state_d = S_GET_B;
                    {OPC_ALU, OP_MVN}:    state_d = S_GET_B;
                    {OPC_ALU, OP_ADD},
                    {OPC_ALU, OP_CMP},
                    {OPC_ALU, OP_AND}:    state_d = S_GET_A;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_WAIT;
                    end
                endcase
            end

            S_GET_A: begin
                nsel    = NSEL_RN;
                loada   = 1'b1;
                state_d = S_GET_B;
            end

            S_GET_B: begin
                nsel    = NSEL_RM;
                loadb   = 1'b1;
                state_d = S_EXEC;
            end

            S_EXEC: begin
                asel  = is_single_operand(opcode, op);
                loads = is_alu_instr(opcode, op);
                loadc = is_alu_instr(opcode, op) && !is_compare(opcode, op);
                if (is_compare(opcode, op)) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_WRITE_REG;
                end
            end

            S_WRITE_REG: begin
                nsel    = NSEL_RD;
                vsel    = VSEL_C;
                write   = 1'b1;
                state_d = S_WAIT;
            end

            S_WRITE_IMM: begin
                nsel    = NSEL_RN;
                vsel    = VSEL_IMM;
                write   = 1'b1;
                state_d = S_WAIT;
            end

            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: stimulus queues expected busy-cycle outputs, monitor compares.
module tb_cpu_controller;

    logic       clk;
    logic       reset;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       illegal;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Packed output bundle: {w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, illegal}
    logic [14:0] expq[$];

    cpu_controller dut (
        .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
        .w(w), .nsel(nsel), .vsel(vsel), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] pack(input logic pw, input logic [2:0] pn, input logic [1:0] pv,
                                         input logic pwr, input logic pla, input logic plb,
                                         input logic plc, input logic pls, input logic pas,
                                         input logic pbs, input logic pil);
        return {pw, pn, pv, pwr, pla, plb, plc, pls, pas, pbs, pil};
    endfunction

    // Hand-written expected vectors for each busy cycle
    localparam logic [14:0] E_DEC      = 15'b0_000_00_0_0_0_0_0_0_0_0;
    localparam logic [14:0] E_DEC_ILL  = 15'b0_000_00_0_0_0_0_0_0_0_1;
    localparam logic [14:0] E_GET_A    = 15'b0_001_00_0_1_0_0_0_0_0_0;
    localparam logic [14:0] E_GET_B    = 15'b0_100_00_0_0_1_0_0_0_0_0;
    localparam logic [14:0] E_EX_2OP   = 15'b0_000_00_0_0_0_1_1_0_0_0;
    localparam logic [14:0] E_EX_CMP   = 15'b0_000_00_0_0_0_0_1_0_0_0;
    localparam logic [14:0] E_EX_1OP   = 15'b0_000_00_0_0_0_1_1_1_0_0;
    localparam logic [14:0] E_WR_REG   = 15'b0_010_00_1_0_0_0_0_0_0_0;
    localparam logic [14:0] E_WR_IMM   = 15'b0_001_10_1_0_0_0_0_0_0_0;
    localparam logic [14:0] E_IDLE     = 15'b1_000_00_0_0_0_0_0_0_0_0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every busy cycle must match the head of the scoreboard; invariants every cycle
    always @(negedge clk) begin
        logic [14:0] act;
        if (mon_en) begin
            act = pack(w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, illegal);
            check("nsel_onehot0", 32'($onehot0(nsel)), 32'd1);
            if (write) check("write_nsel_nonzero", 32'(nsel != 3'b000), 32'd1);
            if (w === 1'b0) begin
                if (expq.size() == 0) begin
                    check("unexpected_busy", 32'(act), 32'(E_IDLE));
                end else begin
                    check("busy_outputs", 32'(act), 32'(expq.pop_front()));
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (w !== 1'b1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        if (w !== 1'b1) check("idle_timeout", 32'(w), 32'd1);
    endtask

    task automatic run_instr(input string name, input logic [2:0] opc, input logic [1:0] opf,
                             input int lat, input logic [14:0] e0, input logic [14:0] e1,
                             input logic [14:0] e2, input logic [14:0] e3, input logic [14:0] e4);
        int cnt = 0;
        logic [14:0] seq [5];
        seq[0] = e0; seq[1] = e1; seq[2] = e2; seq[3] = e3; seq[4] = e4;
        wait_idle();
        opcode = opc;
        op     = opf;
        for (int i = 0; i < lat; i++) expq.push_back(seq[i]);
        s = 1'b1;
        @(posedge clk); #1;
        s = 1'b0;
        while (w !== 1'b1 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({name, "_latency"}, 32'(cnt), 32'(lat));
    endtask

    initial begin
        logic [3:0] wseq;
        reset = 1'b1; s = 1'b0; opcode = 3'b000; op = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              32'(pack(w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, illegal)),
              32'(E_IDLE));
        reset = 1'b0;
        mon_en = 1'b1;

        run_instr("mov_imm", 3'b110, 2'b10, 2, E_DEC, E_WR_IMM, E_IDLE, E_IDLE, E_IDLE);
        run_instr("add",     3'b101, 2'b00, 5, E_DEC, E_GET_A, E_GET_B, E_EX_2OP, E_WR_REG);
        run_instr("cmp",     3'b101, 2'b01, 4, E_DEC, E_GET_A, E_GET_B, E_EX_CMP, E_IDLE);
        run_instr("and",     3'b101, 2'b10, 5, E_DEC, E_GET_A, E_GET_B, E_EX_2OP, E_WR_REG);
        run_instr("mov_reg", 3'b110, 2'b00, 4, E_DEC, E_GET_B, E_EX_1OP, E_WR_REG, E_IDLE);
        run_instr("mvn",     3'b101, 2'b11, 4, E_DEC, E_GET_B, E_EX_1OP, E_WR_REG, E_IDLE);
        run_instr("ill_000", 3'b000, 2'b00, 1, E_DEC_ILL, E_IDLE, E_IDLE, E_IDLE, E_IDLE);
        run_instr("ill_mov01", 3'b110, 2'b01, 1, E_DEC_ILL, E_IDLE, E_IDLE, E_IDLE, E_IDLE);
        run_instr("ill_mov11", 3'b110, 2'b11, 1, E_DEC_ILL, E_IDLE, E_IDLE, E_IDLE, E_IDLE);
        run_instr("ill_111",   3'b111, 2'b10, 1, E_DEC_ILL, E_IDLE, E_IDLE, E_IDLE, E_IDLE);

        // Back-to-back MOV imm with s held high: w must pulse for exactly one cycle
        wait_idle();
        opcode = 3'b110; op = 2'b10;
        expq.push_back(E_DEC); expq.push_back(E_WR_IMM);
        expq.push_back(E_DEC); expq.push_back(E_WR_IMM);
        s = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            wseq[i] = w;
        end
        s = 1'b0;
        check("b2b_w_sequence", 32'(wseq), 32'(4'b0100));
        wait_idle();

        // Reset during GET_B of an ADD abandons it
        opcode = 3'b101; op = 2'b00;
        expq.push_back(E_DEC); expq.push_back(E_GET_A); expq.push_back(E_GET_B);
        s = 1'b1;
        @(posedge clk); #1;
        s = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_in_get_b", 32'(loadb), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("reset_w", 32'(w), 32'd1);
        check("reset_loadb", 32'(loadb), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("reset_no_write", 32'(write), 32'd0);
            @(posedge clk); #1;
        end

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
